// File: rtl/packed_fanout_pipe_if.sv
// Bit-stream in / packed-word out handshake bundle for packed_fanout_pipe.
interface packed_fanout_pipe_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = $clog2(W + 1)
);
    logic [1:0]    i_mode;
    logic          i_valid;
    logic          o_ready;
    logic          i_a;
    logic          i_flush;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_a;
    logic [CW-1:0] o_count;

    // Block side: consumes the bit stream, produces words.
    modport slave (
        input  i_mode, i_valid, i_a, i_flush, i_ready,
        output o_ready, o_valid, o_a, o_count
    );

    // Environment side: drives bits and word-side ready.
    modport master (
        output i_mode, i_valid, i_a, i_flush, i_ready,
        input  o_ready, o_valid, o_a, o_count
    );
endinterface

// File: rtl/packed_fanout_pipe.sv
// Registered 1-bit to W-bit packer: broadcast, LSB-first or MSB-first
// packing, with partial-word flush and a fill counter.
module packed_fanout_pipe #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    packed_fanout_pipe_if.slave  bus
);
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] MODE_BCAST = 2'b00;
    localparam logic [1:0] MODE_MSB   = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    logic [W-1:0]  col_q, col_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    lmode_q, lmode_d;
    logic          o_valid_q, o_valid_d;
    logic [W-1:0]  o_a_q, o_a_d;

    logic [1:0]    mode_eff;
    logic          is_bcast;
    logic          space;
    logic          last_bit;
    logic          ready_c;
    logic          accept;
    logic          complete;
    logic          has_bits;
    logic          flush_fire;
    logic [IW-1:0] bit_idx;
    logic [W-1:0]  col_ins;

    // Handshake decode: mode in force, word-completion and output space.
    always_comb begin
        mode_eff = (cnt_q == '0) ? bus.i_mode : lmode_q;
        is_bcast = (mode_eff == MODE_BCAST) || (mode_eff == MODE_RSVD);
        space    = !o_valid_q || bus.i_ready;
        last_bit = is_bcast || (cnt_q == CW'(W - 1));
        // A pending flush blocks new bits exactly like a stalled completing bit.
        ready_c  = (last_bit || (bus.i_flush && (cnt_q != '0))) ? space : 1'b1;
        accept   = bus.i_valid && ready_c;
        complete = accept && last_bit;
        has_bits = (cnt_q != '0) || (accept && !is_bcast);
        flush_fire = bus.i_flush && !complete && has_bits && space;
        bit_idx  = (mode_eff == MODE_MSB) ? (IW'(W - 1) - IW'(cnt_q)) : IW'(cnt_q);
        col_ins  = col_q;
        col_ins[bit_idx] = bus.i_a;
    end

    // Next-state: collection, fill count, latched mode and output register.
    always_comb begin
        col_d     = col_q;
        cnt_d     = cnt_q;
        lmode_d   = lmode_q;
        o_valid_d = o_valid_q;
        o_a_d     = o_a_q;

        if (accept && (cnt_q == '0)) begin
            lmode_d = bus.i_mode;
        end

        if (complete) begin
            o_a_d     = is_bcast ? {W{bus.i_a}} : col_ins;
            o_valid_d = 1'b1;
            cnt_d     = '0;
            col_d     = '0;
        end else if (flush_fire) begin
            o_a_d     = accept ? col_ins : col_q;
            o_valid_d = 1'b1;
            cnt_d     = '0;
            col_d     = '0;
        end else begin
            if (o_valid_q && bus.i_ready) begin
                o_valid_d = 1'b0;
            end
            if (accept) begin
                col_d = col_ins;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q     <= '0;
            cnt_q     <= '0;
            lmode_q   <= MODE_BCAST;
            o_valid_q <= 1'b0;
            o_a_q     <= '0;
        end else begin
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            lmode_q   <= lmode_d;
            o_valid_q <= o_valid_d;
            o_a_q     <= o_a_d;
        end
    end

    assign bus.o_ready = ready_c;
    assign bus.o_valid = o_valid_q;
    assign bus.o_a     = o_a_q;
    assign bus.o_count = cnt_q;
endmodule

// File: tb/tb_packed_fanout_pipe.sv
// Scoreboard bench for packed_fanout_pipe (W=8).
module tb_packed_fanout_pipe;
    localparam int unsigned W = 8;

    logic clk;
    logic rst;

    packed_fanout_pipe_if #(.W(W)) bus ();

    packed_fanout_pipe #(.W(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    logic [W-1:0] sb[$];
    logic [W-1:0] outq[$];

    // Reference state: collected bits kept as a list, output slot occupancy.
    int       m_cnt;
    bit [1:0] m_mode;
    bit       m_ov;
    bit       m_bits[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] build_word(input bit [1:0] mode);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < m_bits.size(); k++) begin
            if (mode == 2'b10) w[W-1-k] = m_bits[k];
            else               w[k]     = m_bits[k];
        end
        return w;
    endfunction

    // Reference model and monitor, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        bit       sp, bc, cn, rdy, acc, done;
        bit [1:0] eff;
        if (rst) begin
            m_cnt = 0; m_mode = 2'b00; m_ov = 1'b0;
            m_bits.delete();
            sb.delete();
        end else begin
            sp  = !m_ov || bus.i_ready;
            eff = (m_cnt == 0) ? bus.i_mode : m_mode;
            bc  = (eff == 2'b00) || (eff == 2'b11);
            cn  = bc || (m_cnt == W - 1);
            rdy = (cn || (bus.i_flush && m_cnt > 0)) ? sp : 1'b1;
            chk("o_ready", bus.o_ready, rdy);
            chk("o_count", bus.o_count, m_cnt);
            chk("o_valid", bus.o_valid, m_ov);
            if (m_ov && sb.size() > 0) chk("o_a", bus.o_a, sb[0]);

            if (m_ov && bus.i_ready) begin
                outq.push_back(bus.o_a);
                if (sb.size() > 0) void'(sb.pop_front());
                m_ov = 1'b0;
            end

            acc  = bus.i_valid && rdy;
            done = 1'b0;
            if (acc) begin
                if (m_cnt == 0) m_mode = bus.i_mode;
                if (bc) begin
                    sb.push_back({W{bus.i_a}});
                    done = 1'b1;
                end else begin
                    m_bits.push_back(bus.i_a);
                    m_cnt++;
                    if (m_cnt == W) begin
                        sb.push_back(build_word(m_mode));
                        m_bits.delete();
                        m_cnt = 0;
                        done  = 1'b1;
                    end
                end
            end
            if (!done && bus.i_flush && m_cnt > 0 && sp) begin
                sb.push_back(build_word(m_mode));
                m_bits.delete();
                m_cnt = 0;
                done  = 1'b1;
            end
            if (done) m_ov = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one bit until accepted (bounded).
    task automatic send_bit(input bit a, input bit [1:0] mode);
        bit got;
        got = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_a     = a;
        bus.i_mode  = mode;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            got = bus.o_ready;
            @(posedge clk);
            #1;
        end
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
        bus.i_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        pat = 8'b1000_1101;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.i_mode = 2'b00; bus.i_valid = 1'b0; bus.i_a = 1'b0;
        bus.i_flush = 1'b0; bus.i_ready = 1'b1;
        idle(2);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_o_a",     bus.o_a,     0);
        chk("rst_o_count", bus.o_count, 0);
        chk("rst_o_ready", bus.o_ready, 1);
        @(posedge clk); #1;

        // Reset mid-word discards the partial word
        for (int k = 0; k < 5; k++) send_bit(pat[k], 2'b01);
        @(negedge clk);
        chk("pre_rst_count", bus.o_count, 5);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_o_valid", bus.o_valid, 0);
        chk("mid_rst_o_a",     bus.o_a,     0);
        chk("mid_rst_o_count", bus.o_count, 0);
        chk("mid_rst_o_ready", bus.o_ready, 1);
        @(posedge clk); #1;
        outq.delete();
        send_bit(1'b1, 2'b01);
        for (int k = 1; k < 8; k++) send_bit(1'b0, 2'b01);
        idle(2);
        chk("post_rst_words", outq.size(), 1);
        if (outq.size() > 0) chk("post_rst_word", outq[0], 8'h01);

        // Broadcast, including reserved mode
        outq.delete();
        send_bit(1'b1, 2'b00);
        send_bit(1'b0, 2'b00);
        send_bit(1'b1, 2'b00);
        send_bit(1'b0, 2'b11);
        idle(2);
        chk("bc_words", outq.size(), 4);
        if (outq.size() == 4) begin
            chk("bc_w0", outq[0], 8'hFF);
            chk("bc_w1", outq[1], 8'h00);
            chk("bc_w2", outq[2], 8'hFF);
            chk("bc_w3", outq[3], 8'h00);
        end

        // Pack LSB-first
        outq.delete();
        for (int k = 0; k < 8; k++) send_bit(pat[k], 2'b01);
        idle(2);
        chk("lsb_words", outq.size(), 1);
        if (outq.size() > 0) chk("lsb_word", outq[0], 8'h8D);

        // Pack MSB-first, mode switched to broadcast mid-word
        outq.delete();
        for (int k = 0; k < 8; k++) send_bit(pat[k], (k < 3) ? 2'b10 : 2'b00);
        idle(2);
        chk("msb_words", outq.size(), 1);
        if (outq.size() > 0) chk("msb_word", outq[0], 8'hB1);

        // Partial flush
        outq.delete();
        for (int k = 0; k < 3; k++) send_bit(1'b1, 2'b01);
        bus.i_flush = 1'b1;
        idle(1);
        bus.i_flush = 1'b0;
        @(negedge clk);
        chk("flush_count", bus.o_count, 0);
        chk("flush_valid", bus.o_valid, 1);
        @(posedge clk); #1;
        idle(2);
        chk("flush_words", outq.size(), 1);
        if (outq.size() > 0) chk("flush_word", outq[0], 8'h07);

        // Flush with nothing collected
        outq.delete();
        bus.i_flush = 1'b1;
        idle(3);
        bus.i_flush = 1'b0;
        idle(2);
        chk("flush_empty_words", outq.size(), 0);

        // Backpressure: 7 bits accepted, completing bit stalls
        outq.delete();
        bus.i_ready = 1'b0;
        send_bit(1'b1, 2'b00);
        for (int k = 0; k < 7; k++) send_bit(pat[k], 2'b01);
        bus.i_valid = 1'b1; bus.i_a = pat[7]; bus.i_mode = 2'b01;
        idle(2);
        @(negedge clk);
        chk("bp_count", bus.o_count, 7);
        chk("bp_stall", bus.o_ready, 0);
        @(posedge clk); #1;
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", bus.o_ready, 1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        idle(3);
        chk("bp_words", outq.size(), 2);
        if (outq.size() == 2) begin
            chk("bp_w0", outq[0], 8'hFF);
            chk("bp_w1", outq[1], 8'h8D);
        end

        idle(2);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
